byte_serializer: RTL and testbench
==================================

BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state on posedge clk
- reset  in  1  synchronous, active-high reset
- clkEn  in  1  global clock enable; state advances only when high
- bitEn  in  1  serial bit-rate enable; honoured only when clkEn=1
- msbFirst  in  1  1=shift bit7 first, 0=bit0 first; sampled at each byte load
- fillByte  in  8  idle pattern sent when no data byte is available
- fifoEmpty  in  1  empty flag from the upstream byte FIFO
- fifoData  in  8  registered FIFO head (head byte appears one clkEn after a write/pop)
- fifoRdEn  out  1  pop request to the FIFO; combinational
- sdata  out  1  serial data bit, registered
- sdataEn  out  1  one-clk pulse marking a new sdata bit
- byteStart  out  1  one-clk pulse coincident with sdataEn on a byte's first bit
- fillActive  out  1  high while the byte being shifted is fillByte
- underflow  out  1  one-clk pulse when fill replaces data after data has started
REQ-002 Reset SHALL be synchronous and active-high on port reset; clk SHALL be the only clock.

Function
REQ-003 Prefetch FSM states SHALL be IDLE, SETTLE and FULL; it advances only on clkEn=1.
REQ-004 IDLE -> SETTLE when fifoEmpty=0; otherwise stay in IDLE.
REQ-005 In SETTLE with fifoEmpty=0, the block SHALL capture fifoData into nextByte, set nextValid=1 and go to FULL; with fifoEmpty=1 it SHALL return to IDLE.
REQ-006 fifoRdEn SHALL equal (state==SETTLE && !fifoEmpty && clkEn) and SHALL never be asserted in IDLE or FULL.
REQ-007 FULL -> IDLE in the cycle the shifter consumes nextByte, which clears nextValid; two clkEn cycles SHALL therefore separate consecutive pops, and each captured byte SHALL be a refreshed head.
REQ-008 Shifter: 8-bit shift register plus 3-bit bitCnt; on clkEn&bitEn it SHALL drive sdata with the current bit, pulse sdataEn, shift and increment bitCnt (wrapping 7->0).
REQ-009 At bitCnt=7 with clkEn&bitEn, the shifter SHALL load nextByte (fillActive<=0) if nextValid=1, else load fillByte (fillActive<=1).
REQ-010 Bit order SHALL follow msbFirst as sampled at load; changes mid-byte SHALL have no effect until the next load.
REQ-011 byteStart SHALL pulse with the sdataEn of bit 0 of every byte, including fill bytes.
REQ-012 underflow SHALL pulse for one clk at a fill load only if at least one data byte has been loaded since reset.
REQ-013 If consumption and SETTLE capture coincide, capture SHALL take priority over the consume: the consume is evaluated against the old nextValid, and the new byte waits for the next boundary.
REQ-014 With clkEn=0, no state, output register or pulse SHALL change, and the pulses SHALL read 0.
REQ-015 Sustained throughput SHALL be one byte per 8 bitEn pulses whenever bitEn spacing is at least 3 clkEn cycles.

Reset
REQ-016 On reset the block SHALL set: FSM=IDLE, nextValid=0, shift register=fillByte, bitCnt=0, fillActive=1, sdata=0, sdataEn=0, byteStart=0, underflow=0, started flag=0.
REQ-017 Reset mid-byte SHALL abandon the byte in progress and any prefetched byte without popping the FIFO; reset has priority over clkEn.

Structure
REQ-018 The FSM state encoding (IDLE/SETTLE/FULL) and the constant BYTE_BITS=8 SHALL live in the shared telemetry package.
REQ-019 The block SHALL be flat, with no sub-modules; the FIFO is instantiated by the parent.

Verification
REQ-020 After reset, with an empty FIFO and bitEn every 4th clk: output is fillByte 8'hA5 repeated, byteStart every 8 bits, underflow never asserted.
REQ-021 Write 8'h3C, 8'hF0, msbFirst=1: after the current fill byte, sdata=0011_1100 then 1111_0000; exactly 2 fifoRdEn pulses occur, at least 2 clkEn cycles apart.
REQ-022 Same bytes with msbFirst=0: sdata=0011_1100 then 0000_1111; toggling msbFirst mid-byte does not alter the current byte.
REQ-023 One data byte, then the FIFO runs empty: the next byte is fillByte, underflow pulses once and fillActive=1.
REQ-024 Assert reset at bitCnt=4 with nextValid=1: the prefetched byte is dropped, no fifoRdEn occurs, and outputs match REQ-016 on the next clk.
REQ-025 clkEn toggling 1/0 with bitEn held high: bit output occurs only on clkEn=1 cycles, and the sequence matches the clkEn=1 reference run.

Source files
------------

// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the byte serializer: prefetch FSM encoding and byte width.
package byte_serializer_pkg;

    localparam int unsigned BYTE_BITS = 8;
    localparam int unsigned CNT_W     = $clog2(BYTE_BITS);

    typedef enum logic [1:0] {
        PF_IDLE   = 2'd0,
        PF_SETTLE = 2'd1,
        PF_FULL   = 2'd2
    } pf_state_e;

endpackage

// File: rtl/byte_serializer.sv
// Serializes bytes prefetched from an upstream FIFO onto a single bit stream,
// inserting a fill pattern whenever no data byte is ready at a byte boundary.
module byte_serializer
    import byte_serializer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clkEn,
    input  logic                 bitEn,
    input  logic                 msbFirst,
    input  logic [BYTE_BITS-1:0] fillByte,
    input  logic                 fifoEmpty,
    input  logic [BYTE_BITS-1:0] fifoData,
    output logic                 fifoRdEn,
    output logic                 sdata,
    output logic                 sdataEn,
    output logic                 byteStart,
    output logic                 fillActive,
    output logic                 underflow
);

    pf_state_e            state_q;
    logic [BYTE_BITS-1:0] next_byte_q;
    logic                 next_valid_q;
    logic [BYTE_BITS-1:0] shreg_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 msb_q;
    logic                 started_q;
    logic                 sdata_q;
    logic                 sdata_en_q;
    logic                 byte_start_q;
    logic                 fill_active_q;
    logic                 underflow_q;

    logic                 tick;
    logic                 boundary;
    logic                 consume;
    logic                 capture;
    logic                 cur_bit_d;
    logic [BYTE_BITS-1:0] shreg_d;
    logic [BYTE_BITS-1:0] load_byte_d;

    always_comb begin
        tick        = clkEn && bitEn;
        boundary    = tick && (bit_cnt_q == CNT_W'(BYTE_BITS - 1));
        // Consume sees the pre-capture nextValid, so a same-cycle capture waits a byte.
        consume     = boundary && next_valid_q;
        capture     = clkEn && (state_q == PF_SETTLE) && !fifoEmpty;
        cur_bit_d   = msb_q ? shreg_q[BYTE_BITS-1] : shreg_q[0];
        shreg_d     = msb_q ? {shreg_q[BYTE_BITS-2:0], 1'b0}
                            : {1'b0, shreg_q[BYTE_BITS-1:1]};
        load_byte_d = next_valid_q ? next_byte_q : fillByte;
    end

    assign fifoRdEn   = capture && !reset;
    assign sdata      = sdata_q;
    assign sdataEn    = sdata_en_q;
    assign byteStart  = byte_start_q;
    assign fillActive = fill_active_q;
    assign underflow  = underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= PF_IDLE;
            next_byte_q   <= '0;
            next_valid_q  <= 1'b0;
            shreg_q       <= fillByte;
            bit_cnt_q     <= '0;
            msb_q         <= msbFirst;
            started_q     <= 1'b0;
            sdata_q       <= 1'b0;
            sdata_en_q    <= 1'b0;
            byte_start_q  <= 1'b0;
            fill_active_q <= 1'b1;
            underflow_q   <= 1'b0;
        end else begin
            sdata_en_q   <= tick;
            byte_start_q <= tick && (bit_cnt_q == '0);
            underflow_q  <= boundary && !next_valid_q && started_q;

            if (tick) begin
                sdata_q   <= cur_bit_d;
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (boundary) begin
                    shreg_q       <= load_byte_d;
                    msb_q         <= msbFirst;
                    fill_active_q <= !next_valid_q;
                    if (next_valid_q)
                        started_q <= 1'b1;
                end else begin
                    shreg_q <= shreg_d;
                end
            end

            if (clkEn) begin
                case (state_q)
                    PF_IDLE: begin
                        if (!fifoEmpty)
                            state_q <= PF_SETTLE;
                    end
                    PF_SETTLE: begin
                        if (!fifoEmpty) begin
                            next_byte_q  <= fifoData;
                            next_valid_q <= 1'b1;
                            state_q      <= PF_FULL;
                        end else begin
                            state_q <= PF_IDLE;
                        end
                    end
                    PF_FULL: begin
                        if (consume) begin
                            next_valid_q <= 1'b0;
                            state_q      <= PF_IDLE;
                        end
                    end
                    default: state_q <= PF_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer with a registered-head FIFO model and a
// byte-level scoreboard of expected serial bytes.
module tb_byte_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clkEn = 1'b1;
    logic       bitEn = 1'b0;
    logic       msbFirst = 1'b1;
    logic [7:0] fillByte = 8'hA5;
    logic       fifoEmpty = 1'b1;
    logic [7:0] fifoData = 8'h00;
    logic       fifoRdEn;
    logic       sdata;
    logic       sdataEn;
    logic       byteStart;
    logic       fillActive;
    logic       underflow;

    always #5 clk = ~clk;

    byte_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .clkEn      (clkEn),
        .bitEn      (bitEn),
        .msbFirst   (msbFirst),
        .fillByte   (fillByte),
        .fifoEmpty  (fifoEmpty),
        .fifoData   (fifoData),
        .fifoRdEn   (fifoRdEn),
        .sdata      (sdata),
        .sdataEn    (sdataEn),
        .byteStart  (byteStart),
        .fillActive (fillActive),
        .underflow  (underflow)
    );

    typedef struct {
        logic [7:0] bits;
        logic       fill;
        logic       uf;
    } rec_t;

    rec_t       rx_q[$];
    rec_t       exp_q[$];
    logic [7:0] fifo_mem[$];

    int total = 0;
    int bad   = 0;

    // Upstream FIFO: empty flag and head are registered, refreshed on clkEn.
    always @(posedge clk) begin
        if (clkEn) begin
            if (fifoRdEn && fifo_mem.size() > 0)
                void'(fifo_mem.pop_front());
            fifoEmpty <= (fifo_mem.size() == 0);
            fifoData  <= (fifo_mem.size() > 0) ? fifo_mem[0] : 8'h00;
        end
    end

    logic       ce_edge = 1'b1;
    int         mon_cnt = 0;
    logic [7:0] mon_bits = 8'h00;
    logic       mon_fill = 1'b0;
    logic       mon_uf = 1'b0;
    logic       uf_pend = 1'b0;
    int         pops = 0;
    int         ce_cnt = 0;
    int         last_pop = -1000;
    int         min_gap = 1000;
    int         uf_pulses = 0;
    int         ce_viol = 0;
    int         frame_err = 0;

    always @(posedge clk) ce_edge <= clkEn;

    always @(negedge clk) begin
        if (reset) begin
            mon_cnt = 0;
            uf_pend = 1'b0;
        end else begin
            if (clkEn) ce_cnt++;
            if (fifoRdEn) begin
                pops++;
                if (ce_cnt - last_pop < min_gap) min_gap = ce_cnt - last_pop;
                last_pop = ce_cnt;
            end
            if (sdataEn && !ce_edge) ce_viol++;
            if (underflow) begin
                uf_pulses++;
                uf_pend = 1'b1;
            end
            if (sdataEn) begin
                if (byteStart != (mon_cnt == 0)) frame_err++;
                if (byteStart) begin
                    mon_fill = fillActive;
                    mon_uf   = uf_pend;
                    uf_pend  = 1'b0;
                end
                mon_bits = {mon_bits[6:0], sdata};
                mon_cnt++;
                if (mon_cnt == 8) begin
                    rx_q.push_back('{bits: mon_bits, fill: mon_fill, uf: mon_uf});
                    mon_cnt = 0;
                end
            end
        end
    end

    // 0: bitEn every 4th clk, 1: clkEn=bitEn=1, 2: clkEn toggling with bitEn=1
    int mode = 0;
    int div  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        div++;
        case (mode)
            0: begin clkEn = 1'b1; bitEn = (div % 4 == 0); end
            1: begin clkEn = 1'b1; bitEn = 1'b1; end
            default: begin clkEn = ~clkEn; bitEn = 1'b1; end
        endcase
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] rev8(logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic push_exp(logic [7:0] b, logic f, logic u);
        exp_q.push_back('{bits: b, fill: f, uf: u});
    endtask

    task automatic drain(int n, string tag);
        for (int i = 0; i < n; i++) begin
            rec_t e;
            rec_t r;
            int   w;
            e = exp_q.pop_front();
            w = 0;
            while (rx_q.size() == 0 && w < 400) begin
                tick();
                w++;
            end
            total++;
            assert (rx_q.size() != 0) else begin
                bad++;
                $error("FAIL %s[%0d].timeout: observed=no byte expected=byte", tag, i);
            end
            if (rx_q.size() != 0) begin
                r = rx_q.pop_front();
                chk($sformatf("%s[%0d].bits", tag, i), 32'(r.bits), 32'(e.bits));
                chk($sformatf("%s[%0d].fill", tag, i), 32'(r.fill), 32'(e.fill));
                chk($sformatf("%s[%0d].uf", tag, i), 32'(r.uf), 32'(e.uf));
            end
        end
    endtask

    task automatic wait_rx_cnt(int nbytes, int nbits, string tag);
        int w = 0;
        while (!(rx_q.size() == nbytes && mon_cnt == nbits) && w < 600) begin
            tick();
            w++;
        end
        chk({tag, ".sync"}, 32'(w < 600), 32'd1);
    endtask

    task automatic wait_start(string tag);
        wait_rx_cnt(rx_q.size(), 1, tag);
        rx_q.delete();
        exp_q.delete();
    endtask

    int p0;
    int p1;
    int u0;

    initial begin
        // Reset state and idle fill stream
        mode = 0;
        repeat (3) tick();
        chk("rst.sdata", 32'(sdata), 32'd0);
        chk("rst.sdataEn", 32'(sdataEn), 32'd0);
        chk("rst.byteStart", 32'(byteStart), 32'd0);
        chk("rst.underflow", 32'(underflow), 32'd0);
        chk("rst.fillActive", 32'(fillActive), 32'd1);
        chk("rst.fifoRdEn", 32'(fifoRdEn), 32'd0);
        reset = 1'b0;
        rx_q.delete();
        repeat (3) push_exp(8'hA5, 1'b1, 1'b0);
        drain(3, "idle");
        chk("idle.pops", 32'(pops), 32'd0);

        // Two data bytes, MSB first
        wait_start("msb");
        p0 = pops;
        last_pop = -1000;
        min_gap = 1000;
        fifo_mem.push_back(8'h3C);
        fifo_mem.push_back(8'hF0);
        push_exp(8'hA5, 1'b1, 1'b0);
        push_exp(8'h3C, 1'b0, 1'b0);
        push_exp(8'hF0, 1'b0, 1'b0);
        push_exp(8'hA5, 1'b1, 1'b1);
        drain(4, "msb");
        chk("msb.pops", 32'(pops - p0), 32'd2);
        chk("msb.popgap", 32'(min_gap >= 2), 32'd1);

        // LSB first, with msbFirst toggled during the second data byte
        msbFirst = 1'b0;
        wait_start("lsb");
        p0 = pops;
        fifo_mem.push_back(8'h3C);
        fifo_mem.push_back(8'hF0);
        push_exp(8'hA5, 1'b1, 1'b1);
        push_exp(rev8(8'h3C), 1'b0, 1'b0);
        push_exp(rev8(8'hF0), 1'b0, 1'b0);
        push_exp(8'hA5, 1'b1, 1'b1);
        wait_rx_cnt(2, 3, "lsb.tog1");
        msbFirst = 1'b1;
        wait_rx_cnt(2, 6, "lsb.tog0");
        msbFirst = 1'b0;
        drain(4, "lsb");
        chk("lsb.pops", 32'(pops - p0), 32'd2);

        // Single byte then FIFO runs dry
        wait_start("dry");
        u0 = uf_pulses;
        fifo_mem.push_back(8'h96);
        push_exp(8'hA5, 1'b1, 1'b1);
        push_exp(rev8(8'h96), 1'b0, 1'b0);
        push_exp(8'hA5, 1'b1, 1'b1);
        drain(2, "dry");
        chk("dry.ufcount", 32'(uf_pulses - u0), 32'd1);
        drain(1, "dry.fill");

        // Reset mid-byte with a prefetched byte pending
        wait_start("rstmid");
        p0 = pops;
        fifo_mem.push_back(8'h77);
        begin
            int w = 0;
            while (pops == p0 && w < 100) begin
                tick();
                w++;
            end
            chk("rstmid.prefetch", 32'(pops - p0), 32'd1);
        end
        wait_rx_cnt(0, 4, "rstmid.bit4");
        reset = 1'b1;
        p1 = pops;
        tick();
        chk("rstmid.sdata", 32'(sdata), 32'd0);
        chk("rstmid.sdataEn", 32'(sdataEn), 32'd0);
        chk("rstmid.byteStart", 32'(byteStart), 32'd0);
        chk("rstmid.underflow", 32'(underflow), 32'd0);
        chk("rstmid.fillActive", 32'(fillActive), 32'd1);
        chk("rstmid.fifoRdEn", 32'(fifoRdEn), 32'd0);
        tick();
        reset = 1'b0;
        rx_q.delete();
        exp_q.delete();
        push_exp(8'hA5, 1'b1, 1'b0);
        push_exp(8'hA5, 1'b1, 1'b0);
        drain(2, "rstmid");
        chk("rstmid.pops", 32'(pops - p1), 32'd0);

        // Reference run: clkEn and bitEn held high
        mode = 1;
        msbFirst = 1'b1;
        reset = 1'b1;
        tick();
        fifo_mem.push_back(8'h3C);
        fifo_mem.push_back(8'hF0);
        fifo_mem.push_back(8'h81);
        repeat (4) tick();
        rx_q.delete();
        exp_q.delete();
        reset = 1'b0;
        push_exp(8'hA5, 1'b1, 1'b0);
        push_exp(8'h3C, 1'b0, 1'b0);
        push_exp(8'hF0, 1'b0, 1'b0);
        push_exp(8'h81, 1'b0, 1'b0);
        push_exp(8'hA5, 1'b1, 1'b1);
        drain(5, "ref");

        // Same sequence with clkEn toggling every clk
        mode = 2;
        reset = 1'b1;
        tick();
        fifo_mem.push_back(8'h3C);
        fifo_mem.push_back(8'hF0);
        fifo_mem.push_back(8'h81);
        repeat (6) tick();
        rx_q.delete();
        exp_q.delete();
        reset = 1'b0;
        push_exp(8'hA5, 1'b1, 1'b0);
        push_exp(8'h3C, 1'b0, 1'b0);
        push_exp(8'hF0, 1'b0, 1'b0);
        push_exp(8'h81, 1'b0, 1'b0);
        push_exp(8'hA5, 1'b1, 1'b1);
        drain(5, "ceTog");

        chk("ceTog.viol", 32'(ce_viol), 32'd0);
        chk("frame.err", 32'(frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
